// File: rtl/multiport_ram_ctrl.sv
// Parametrised RAM with one write port, N_RD registered read ports and a
// hardware clear sequencer that zeroes every entry after reset or on request.
module multiport_ram_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int N_RD   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     clr,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   raddr,
    output logic [N_RD*DATA_W-1:0]   rdata,
    output logic [N_RD-1:0]          rvalid,
    output logic                     busy
);

    localparam int                LP_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_clrPtr;
    logic                    r_busy;
    logic [N_RD*DATA_W-1:0]  r_rdata;
    logic [N_RD-1:0]         r_rvalid;
    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic                    w_wrAccept;
    logic [ADDR_W-1:0]       w_raddr  [N_RD];
    logic [DATA_W-1:0]       w_rdWord [N_RD];

    // A write lands only in READY, never alongside a clear request, and never out of range.
    assign w_wrAccept = (r_state == READY) && ce && we && !clr
                        && ({1'b0, waddr} < LP_DEPTH);

    // Write-first: a same-edge write to the read address is forwarded to that port.
    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            w_raddr[i]  = raddr[i*ADDR_W +: ADDR_W];
            w_rdWord[i] = '0;
            if (w_wrAccept && (w_raddr[i] == waddr)) begin
                w_rdWord[i] = wdata;
            end else if ({1'b0, w_raddr[i]} < LP_DEPTH) begin
                w_rdWord[i] = r_mem[w_raddr[i][LP_IDX_W-1:0]];
            end
        end
    end

    // The array itself has no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clrPtr[LP_IDX_W-1:0]] <= '0;
        end else if (w_wrAccept) begin
            r_mem[waddr[LP_IDX_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= CLEAR;
            r_clrPtr <= '0;
            r_busy   <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= '0;
            case (r_state)
                CLEAR: begin
                    r_clrPtr <= r_clrPtr + ADDR_W'(1);
                    if (r_clrPtr == LP_LAST) begin
                        r_state  <= READY;
                        r_busy   <= 1'b0;
                        r_clrPtr <= '0;
                    end
                end
                READY: begin
                    for (int i = 0; i < N_RD; i++) begin
                        if (ce && rd_en[i]) begin
                            r_rdata[i*DATA_W +: DATA_W] <= w_rdWord[i];
                            r_rvalid[i]                 <= 1'b1;
                        end
                    end
                    if (clr) begin
                        r_state  <= CLEAR;
                        r_clrPtr <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = r_busy;

endmodule

// File: tb/tb_multiport_ram_ctrl.sv
// Directed self-checking bench: default 16x8 / 3-port instance plus a
// 12-entry / 4-port instance for out-of-range and mid-clear reset behaviour.
module tb_multiport_ram_ctrl;

    logic        clk;
    logic        rst, ce, we, clr;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
    logic [2:0]  rdEn;
    logic [11:0] raddr;
    logic [23:0] rdata;
    logic [2:0]  rvalid;
    logic        busy;

    logic        rst12, ce12, we12, clr12;
    logic [3:0]  waddr12;
    logic [7:0]  wdata12;
    logic [3:0]  rdEn12;
    logic [15:0] raddr12;
    logic [31:0] rdata12;
    logic [3:0]  rvalid12;
    logic        busy12;

    int checkCount = 0;
    int failCount  = 0;

    multiport_ram_ctrl u_dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .rd_en(rdEn), .raddr(raddr), .rdata(rdata),
        .rvalid(rvalid), .busy(busy)
    );

    multiport_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .N_RD(4)) u_dut12 (
        .clk(clk), .rst(rst12), .ce(ce12), .we(we12), .waddr(waddr12), .wdata(wdata12),
        .clr(clr12), .rd_en(rdEn12), .raddr(raddr12), .rdata(rdata12),
        .rvalid(rvalid12), .busy(busy12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input bit useSmall, output int edges);
        edges = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            edges++;
            if ((useSmall ? busy12 : busy) == 1'b0) break;
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [3:0] wa,
                                 input logic [7:0] wd, input logic [2:0] re, input logic [11:0] ra);
        ce = c; we = w; waddr = wa; wdata = wd; rdEn = re; raddr = ra;
    endtask

    task automatic readAllZero(input string tag);
        logic [3:0] a0, a1, a2;
        int bad;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            a0 = 4'(a);
            a1 = 4'(a + 5);
            a2 = 4'(15 - a);
            applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 3'b111, {a2, a1, a0});
            tick();
            if (rdata !== 24'h0 || rvalid !== 3'b111) bad++;
        end
        checkOutput(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        int edges;
        int rvalidSeen;

        rst = 1'b1; clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 3'b000, 12'd0);
        rst12 = 1'b1; ce12 = 1'b0; we12 = 1'b0; clr12 = 1'b0;
        waddr12 = '0; wdata12 = '0; rdEn12 = '0; raddr12 = '0;

        repeat (3) tick();
        checkOutput("reset_busy", 64'(busy), 64'd1);
        checkOutput("reset_rvalid", 64'(rvalid), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'd0);

        rst = 1'b0;
        waitIdle(1'b0, edges);
        checkOutput("reset_clear_edges", 64'(edges), 64'd16);
        readAllZero("reset_read_all_zero");

        applyStimulus(1'b1, 1'b1, 4'd3, 8'hA5, 3'b000, 12'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd15, 8'h3C, 3'b000, 12'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 3'b111, {4'd3, 4'd15, 4'd3});
        tick();
        checkOutput("wr_rd_rdata", 64'(rdata), 64'hA53CA5);
        checkOutput("wr_rd_rvalid", 64'(rvalid), 64'b111);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 3'b000, 12'd0);
        tick();
        checkOutput("idle_rvalid", 64'(rvalid), 64'b000);
        checkOutput("idle_rdata_hold", 64'(rdata), 64'hA53CA5);

        applyStimulus(1'b1, 1'b1, 4'd6, 8'h66, 3'b000, 12'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd7, 8'h11, 3'b000, 12'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 4'd7, 8'h77, 3'b011, {4'd0, 4'd7, 4'd6});
        tick();
        checkOutput("bypass_rdata", 64'(rdata), 64'hA57766);
        checkOutput("bypass_rvalid", 64'(rvalid), 64'b011);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 3'b001, {4'd0, 4'd0, 4'd7});
        tick();
        checkOutput("bypass_persist", 64'(rdata[7:0]), 64'h77);

        applyStimulus(1'b0, 1'b1, 4'd2, 8'hFF, 3'b111, {4'd2, 4'd2, 4'd2});
        tick();
        checkOutput("gate_rvalid", 64'(rvalid), 64'b000);
        checkOutput("gate_rdata_hold", 64'(rdata), 64'hA57777);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 3'b001, {4'd0, 4'd0, 4'd2});
        tick();
        checkOutput("gate_mem2", 64'(rdata[7:0]), 64'h00);

        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 1'b1, 4'(a), 8'(8'h80 + a), 3'b000, 12'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 4'd0, 8'h99, 3'b001, {4'd0, 4'd0, 4'd5});
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_read_old", 64'(rdata[7:0]), 64'h85);
        checkOutput("clr_rvalid", 64'(rvalid), 64'b001);
        checkOutput("clr_busy", 64'(busy), 64'd1);

        applyStimulus(1'b1, 1'b1, 4'd4, 8'h55, 3'b111, {4'd4, 4'd4, 4'd4});
        edges = 0;
        rvalidSeen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            edges++;
            if (rvalid !== 3'b000) rvalidSeen++;
            if (busy == 1'b0) break;
        end
        checkOutput("clr_busy_edges", 64'(edges), 64'd16);
        checkOutput("clr_reads_ignored", 64'(rvalidSeen), 64'd0);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'd0, 3'b011, {4'd0, 4'd4, 4'd0});
        tick();
        checkOutput("clr_addr0_addr4", 64'(rdata[15:0]), 64'h0000);
        readAllZero("clr_read_all_zero");
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 3'b000, 12'd0);

        rst12 = 1'b0;
        waitIdle(1'b1, edges);
        checkOutput("d12_clear_edges", 64'(edges), 64'd12);

        ce12 = 1'b1; we12 = 1'b1; waddr12 = 4'd11; wdata12 = 8'h44;
        tick();
        waddr12 = 4'd13; wdata12 = 8'hEE; rdEn12 = 4'b0011;
        raddr12 = {4'd0, 4'd0, 4'd11, 4'd13};
        tick();
        checkOutput("d12_oor_rdata", 64'(rdata12[15:0]), 64'h4400);
        checkOutput("d12_oor_rvalid", 64'(rvalid12), 64'b0011);
        we12 = 1'b0; rdEn12 = 4'b1101;
        raddr12 = {4'd11, 4'd13, 4'd0, 4'd1};
        tick();
        checkOutput("d12_no_alias", 64'(rdata12), 64'h44004400);
        checkOutput("d12_rvalid4", 64'(rvalid12), 64'b1101);
        ce12 = 1'b0; rdEn12 = 4'b0000;

        rst12 = 1'b1;
        #1;
        checkOutput("d12_async_rdata", 64'(rdata12), 64'h0);
        checkOutput("d12_async_busy", 64'(busy12), 64'd1);
        repeat (2) tick();
        rst12 = 1'b0;
        repeat (5) tick();
        rst12 = 1'b1;
        #1;
        checkOutput("d12_midclr_busy", 64'(busy12), 64'd1);
        repeat (2) tick();
        rst12 = 1'b0;
        waitIdle(1'b1, edges);
        checkOutput("d12_restart_edges", 64'(edges), 64'd12);
        ce12 = 1'b1; rdEn12 = 4'b0001; raddr12 = {4'd0, 4'd0, 4'd0, 4'd11};
        tick();
        checkOutput("d12_recleared", 64'(rdata12[7:0]), 64'h00);
        checkOutput("d12_recleared_valid", 64'(rvalid12), 64'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/multiport_ram_ctrl.md
Name: multiport_ram_ctrl

Overview:
- Parametrised successor to the fixed-size input, filter and output RAMs in the memory subsystem.
- One write port and N_RD independent read ports with registered outputs and per-port read-valid.
- Hardware clear sequencer zeroes all contents after reset or on request; `busy` is high while clearing.
- Instantiated once per matrix or result buffer (input, filter, serial, parallel outputs) with per-instance parameters.

Parameters:
- DATA_W, 8, width of each word.
- ADDR_W, 4, address width. Requires DEPTH <= 2**ADDR_W.
- DEPTH, 16, number of implemented entries.
- N_RD, 3, number of read ports (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  chip enable; gates all reads and writes.
- we  input  1  write enable; qualified by ce.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- clr  input  1  soft-clear request (one-cycle pulse honoured).
- rd_en  input  N_RD  per-port read request; qualified by ce.
- raddr  input  N_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rdata  output  N_RD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W].
- rvalid  output  N_RD  per-port one-cycle valid for rdata.
- busy  output  1  high while the clear sequence runs.

Behaviour:
- States: CLEAR, READY.
  - Reset (async, while rst=1): state=CLEAR, clr_ptr=0, busy=1, rdata=0, rvalid=0. Memory array is not async-reset.
- CLEAR state:
  - Each rising edge writes 0 to mem[clr_ptr], then clr_ptr++.
  - On the edge writing entry DEPTH-1: state goes to READY, busy goes to 0.
  - Exactly DEPTH edges after rst release, busy=0.
- In CLEAR:
  - ce/we/rd_en and clr are ignored.
  - rvalid=0; rdata holds its value.
- In READY with clr=1: next state is CLEAR, clr_ptr=0, busy=1 from the next cycle.
  - Any write presented in that same cycle is dropped.
  - Reads in that same cycle are serviced normally and return the pre-clear contents.
- Write: in READY, with ce=1, we=1, clr=0 and waddr<DEPTH, mem[waddr]<=wdata at the edge.
- Read, port i:
  - In READY with ce=1 and rd_en[i]=1, at the edge: rdata[i]<=word and rvalid[i]<=1. Latency is 1 cycle.
  - Otherwise rvalid[i]<=0 and rdata[i] holds.
- Write-first bypass: if a write is accepted at the same edge and raddr[i]==waddr, rdata[i] gets wdata, not the old word.
- Out of range:
  - raddr[i]>=DEPTH returns 0 with rvalid[i]=1.
  - waddr>=DEPTH is ignored; no wrap, no alias.
- Multiple ports may read the same address in the same cycle; all return an identical word.
- Ports are independent; there is no arbitration and no stall.
- rst asserted mid-clear or mid-read aborts immediately to the reset values above. The clear restarts from entry 0 after release.

Test Plan:
- Reset release, defaults: hold rst 3 cycles then release, count edges. Required: busy=1 for exactly 16 edges, then 0; read of all 16 addresses on 3 ports returns 0x00 with rvalid=1 one cycle after request.
- Write then read: write 0xA5 to addr 3 and 0x3C to addr 15; next cycle read ports 0/1/2 at addrs 3/15/3. Required: one cycle later rdata = 0xA5/0x3C/0xA5, rvalid=3'b111; following idle cycle rvalid=3'b000 and rdata unchanged.
- Bypass: addr 7 holds 0x11; same cycle write 0x77 to addr 7 and read addr 7 on port 1, addr 6 on port 0. Required: port1=0x77, port0=old mem[6]; subsequent read of addr 7 returns 0x77.
- Gating: ce=0 with we=1, wdata=0xFF, waddr=2, rd_en=3'b111. Required: rvalid=0 and mem[2] unchanged. During busy, write 0x55 to addr 4. Required: after busy falls, addr 4 reads 0x00.
- Soft clear: fill addrs 0-15 with 0x80+addr; pulse clr together with write 0x99 to addr 0 and read addr 5. Required: port returns 0x85; busy=1 for 16 cycles; all entries read 0x00 afterwards, including addr 0 (write dropped).
- DEPTH=12, N_RD=4: write 0xEE to addr 13, read addr 13 and addr 11. Required: addr 13 returns 0x00 with rvalid=1; addr 11 unaffected; reset clear lasts 12 cycles. Assert rst at clear cycle 5: busy stays 1, clear restarts and completes 12 edges after release.
